// File: rtl/alu_pkg.sv
// Shared definitions for the ALU arbiter: op codes, datapath width and sequencer states.
package alu_pkg;

  localparam int unsigned ALU_W = 32;

  localparam logic [3:0] ALU_AND = 4'd0;
  localparam logic [3:0] ALU_OR  = 4'd1;
  localparam logic [3:0] ALU_ADD = 4'd2;
  localparam logic [3:0] ALU_SLL = 4'd3;
  localparam logic [3:0] ALU_SUB = 4'd4;
  localparam logic [3:0] ALU_SRL = 4'd5;
  localparam logic [3:0] ALU_MUL = 4'd6;
  localparam logic [3:0] ALU_XOR = 4'd7;
  localparam logic [3:0] ALU_SLT = 4'd8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } state_t;

  function automatic logic op_legal(input logic [3:0] op);
    return op <= ALU_SLT;
  endfunction

endpackage

// File: rtl/alu_arbiter_rr_picker.sv
// Combinational round-robin picker: first asserted request after ptr wins.
module rr_picker #(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx
);

  always_comb begin
    logic          found;
    logic [IW-1:0] cand;
    grant = '0;
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    // Scan ptr+1 .. ptr+N so the previous winner is considered last.
    for (int unsigned i = 1; i <= N; i++) begin
      cand = IW'((32'(ptr) + i) % N);
      if (!found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        idx         = cand;
      end
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin sequencer sharing one registered ALU among NREQ requesters,
// with a valid/ready request side and a valid/ready response side.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDW  = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*ALU_W-1:0] req_a,
  input  logic [NREQ*ALU_W-1:0] req_b,
  input  logic [NREQ*4-1:0]     req_op,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [IDW-1:0]        resp_id,
  output logic [ALU_W-1:0]      resp_result,
  output logic                  resp_zero,
  output logic                  resp_err,
  output logic                  busy,
  output logic [ALU_W-1:0]      alu_a,
  output logic [ALU_W-1:0]      alu_b,
  output logic [3:0]            alu_control,
  input  logic [ALU_W-1:0]      alu_result,
  input  logic                  alu_zero
);

  state_t           state;
  logic [IDW-1:0]   ptr;
  logic [NREQ-1:0]  grant;
  logic [IDW-1:0]   win;
  logic [ALU_W-1:0] win_a;
  logic [ALU_W-1:0] win_b;
  logic [3:0]       win_op;

  rr_picker #(.N(NREQ), .IW(IDW)) u_picker (
    .req   (req_valid),
    .ptr   (ptr),
    .grant (grant),
    .idx   (win)
  );

  // One-hot grant makes an OR-mux of the winner's fields sufficient.
  always_comb begin
    win_a  = '0;
    win_b  = '0;
    win_op = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        win_a  = req_a[ALU_W*i +: ALU_W];
        win_b  = req_b[ALU_W*i +: ALU_W];
        win_op = req_op[4*i +: 4];
      end
    end
  end

  always_comb begin
    req_ready  = (state == IDLE) ? grant : '0;
    resp_valid = (state == RESP);
    busy       = (state != IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      ptr         <= IDW'(NREQ - 1);
      resp_id     <= '0;
      resp_result <= '0;
      resp_zero   <= 1'b0;
      resp_err    <= 1'b0;
      alu_a       <= '0;
      alu_b       <= '0;
      alu_control <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|grant) begin
            ptr     <= win;
            resp_id <= win;
            if (op_legal(win_op)) begin
              alu_a       <= win_a;
              alu_b       <= win_b;
              alu_control <= win_op;
              state       <= EXEC;
            end else begin
              resp_result <= '0;
              resp_zero   <= 1'b0;
              resp_err    <= 1'b1;
              state       <= RESP;
            end
          end
        end
        EXEC: state <= WAIT;
        WAIT: begin
          resp_result <= alu_result;
          resp_zero   <= alu_zero;
          resp_err    <= 1'b0;
          state       <= RESP;
        end
        RESP: begin
          if (resp_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
